line_tracker: RTL

Decision stage directly upstream of the motor driver. It samples the three infrared line sensors, debounces them, and runs a steering state machine. It outputs the 2-bit `mode` and 10-bit `speed` that the motor driver consumes; `speed` ramps gradually so the PWM duty never jumps.

---
 rtl/line_tracker.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/line_tracker.sv
// line_tracker: debounces three IR line sensors and steers via a small FSM.
// Emits registered mode/speed/lost for the motor driver; speed ramps toward a per-state target.
//
// state  | meaning
// IDLE   | stopped, waiting for en with a filtered pattern
// FWD    | line centred, cruise speed
// LEFT   | line off to the left, turning left
// RIGHT  | line off to the right, turning right
// SEARCH | line lost, turning toward last_dir until timeout
// HALT   | search timed out, sticky until en drops
module line_tracker #(
  parameter int          FILTER_CYCLES = 100000,
  parameter int          LOST_TIMEOUT  = 50000000,
  parameter int          RAMP_DIV      = 100000,
  parameter logic [9:0]  RAMP_STEP     = 10'd50,
  parameter logic [9:0]  CRUISE_SPEED  = 10'd700,
  parameter logic [9:0]  TURN_SPEED    = 10'd500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor,
  output logic [1:0] mode,
  output logic [9:0] speed,
  output logic       lost
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int TW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] LOST_LAST = TW'(LOST_TIMEOUT - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD, S_LEFT, S_RIGHT, S_SEARCH, S_HALT
  } state_t;

  logic          en_s1, en_s2;
  logic [2:0]    sen_s1, sen_s2;
  logic [FW-1:0] stab_cnt;
  logic [2:0]    filt;
  state_t        state, state_nx;
  logic          dir_left, dir_left_nx;
  logic [TW-1:0] search_cnt;
  logic [PW-1:0] pre_cnt;
  logic [9:0]    target, speed_nx;
  logic [10:0]   up_sum, dn_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s1  <= 1'b0;
      en_s2  <= 1'b0;
      sen_s1 <= 3'b000;
      sen_s2 <= 3'b000;
    end else begin
      en_s1  <= en;
      en_s2  <= en_s1;
      sen_s1 <= sensor;
      sen_s2 <= sen_s1;
    end
  end

  // sen_s1 is the next value of sen_s2, so comparing them restarts the count
  // on the same edge the synchronized pattern changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
      filt     <= 3'b000;
    end else begin
      if (sen_s1 != sen_s2)
        stab_cnt <= '0;
      else if (stab_cnt != FILT_LAST)
        stab_cnt <= stab_cnt + FW'(1);
      if (stab_cnt == FILT_LAST)
        filt <= sen_s2;
    end
  end

  function automatic state_t decode(input logic [2:0] f, input state_t cur);
    state_t nx;
    case (f)
      3'b010, 3'b111: nx = S_FWD;
      3'b100, 3'b110: nx = S_LEFT;
      3'b001, 3'b011: nx = S_RIGHT;
      3'b101:         nx = (cur == S_IDLE) ? S_FWD : cur;
      default:        nx = S_SEARCH;
    endcase
    return nx;
  endfunction

  always_comb begin
    state_nx = state;
    if (!en_s2) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_HALT:   state_nx = S_HALT;
        S_SEARCH: state_nx = (filt == 3'b000 && search_cnt == LOST_LAST) ? S_HALT
                                                                         : decode(filt, state);
        default:  state_nx = decode(filt, state);
      endcase
    end
  end

  always_comb begin
    dir_left_nx = dir_left;
    if (state_nx == S_LEFT)
      dir_left_nx = 1'b1;
    else if (state_nx == S_RIGHT)
      dir_left_nx = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dir_left   <= 1'b1;
      search_cnt <= '0;
      mode       <= 2'b00;
      lost       <= 1'b0;
    end else begin
      state    <= state_nx;
      dir_left <= dir_left_nx;
      if (state != S_SEARCH)
        search_cnt <= '0;
      else if (search_cnt != LOST_LAST)
        search_cnt <= search_cnt + TW'(1);
      lost <= (state_nx == S_HALT);
      case (state_nx)
        S_FWD:    mode <= 2'b01;
        S_LEFT:   mode <= 2'b10;
        S_RIGHT:  mode <= 2'b11;
        S_SEARCH: mode <= dir_left_nx ? 2'b10 : 2'b11;
        default:  mode <= 2'b00;
      endcase
    end
  end

  always_comb begin
    case (state)
      S_FWD:                     target = CRUISE_SPEED;
      S_LEFT, S_RIGHT, S_SEARCH: target = TURN_SPEED;
      default:                   target = 10'd0;
    endcase
  end

  assign up_sum  = {1'b0, speed} + {1'b0, RAMP_STEP};
  assign dn_diff = {1'b0, speed} - {1'b0, RAMP_STEP};

  // Bit 10 of dn_diff is the borrow, so a step below zero clamps to target.
  always_comb begin
    speed_nx = speed;
    if (speed < target)
      speed_nx = (up_sum > {1'b0, target}) ? target : up_sum[9:0];
    else if (speed > target)
      speed_nx = (dn_diff[10] || dn_diff[9:0] < target) ? target : dn_diff[9:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      speed   <= 10'd0;
    end else begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        speed   <= speed_nx;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

endmodule
